reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised general-purpose register file with write-to-read bypass,
//  per-register pending scoreboard and a sequenced bulk-clear engine.
//  Sits between the datapath bus and the ALU/SR muxes. It supersedes the
//  fixed 8x16 file for pipelined control units, which must track in-flight
//  writes.
// PARAMETERS
//  WIDTH   16  data width of each register and of Bus_In/SRxOUT
//  NREGS   8   number of registers (power of two, >=2)
//  BYPASS  1   1: a same-cycle write is forwarded to the reads; 0: reads show stored value
//  (localparam AW = $clog2(NREGS): register index width)
// PORTS
//  Clk         in   1      system clock, all state on posedge
//  Reset       in   1      synchronous, active-high reset
//  LD_REG      in   1      write strobe: reg[DR_In] <= Bus_In
//  DR_In       in   AW     write destination index
//  Bus_In      in   WIDTH  write data
//  Issue       in   1      mark reg[Issue_DR] pending (a producer is in flight)
//  Issue_DR    in   AW     index to mark pending
//  Clear_Req   in   1      request a sequenced clear of all registers
//  SR1_In      in   AW     read port 1 index
//  SR2_In      in   AW     read port 2 index
//  SR1OUT      out  WIDTH  read port 1 data (combinational)
//  SR2OUT      out  WIDTH  read port 2 data (combinational)
//  SR1_Pend    out  1      read port 1 register has an outstanding producer
//  SR2_Pend    out  1      read port 2 register has an outstanding producer
//  Clear_Busy  out  1      clear sequence in progress
// BEHAVIOUR
//  Reset (sync, one edge): all regs=0, pending=0, FSM=IDLE, clear index=0.
//   Afterwards SRxOUT=0, SRx_Pend=0, Clear_Busy=0. Reset wins over every other input.
//  Reads: SRxOUT = reg[SRx_In], zero latency. If BYPASS=1 and LD_REG and
//   DR_In==SRx_In (FSM=IDLE), SRxOUT = Bus_In. Write commits at the next posedge.
//  Scoreboard: Issue sets pending[Issue_DR]; LD_REG clears pending[DR_In].
//   If both target the same index in one cycle, the set wins (a new producer).
//   SRx_Pend = pending[SRx_In] & ~(BYPASS & LD_REG & DR_In==SRx_In & IDLE).
//  FSM IDLE:  Clear_Req -> CLEAR next cycle. At that edge the clear index is
//   set to 0 and all pending bits are cleared. LD_REG/Issue in that same cycle
//   are still honoured, but the clear overwrites them.
//  FSM CLEAR: Clear_Busy=1. Each cycle reg[idx] <= 0 and idx++. After the
//   cycle with idx==NREGS-1, go to IDLE. Total NREGS cycles with Clear_Busy=1.
//   LD_REG, Issue and Clear_Req are ignored. No bypass. Reads return the
//   array contents (registers not yet cleared keep their old values).
//   SRx_Pend=0. Reset during CLEAR aborts the sequence and goes to IDLE.
//  Index wrap: idx is AW bits wide. The end of the sequence is detected on
//   NREGS-1, not on overflow.
//  Index inputs are always in range (power-of-two NREGS). No X is driven on outputs.
// TESTING
//  1 Reset, then write 16'h1234 to R3, read SR1=3 next cycle -> SR1OUT=16'h1234, SR1_Pend=0.
//  2 BYPASS=1: LD_REG to R5 with Bus_In=16'hBEEF, SR2_In=5 in the same cycle
//    -> SR2OUT=16'hBEEF that cycle. BYPASS=0 -> SR2OUT=old R5 that cycle, 16'hBEEF the next.
//  3 Issue R2, then SR1_In=2 -> SR1_Pend=1. LD_REG R2=16'h0007 -> SR1_Pend=0
//    in the write cycle (BYPASS=1) and after. Issue+LD_REG to R2 in one cycle -> pending stays 1.
//  4 Fill R0..R7 with 16'hFFFF, pulse Clear_Req -> Clear_Busy high exactly 8 cycles.
//    R0 reads 0 after cycle 1, all reads 0 after. A LD_REG during CLEAR has no effect.
//  5 Reset asserted on the 4th CLEAR cycle -> next cycle Clear_Busy=0, all regs 0.
//    A new LD_REG is accepted immediately.
//  6 Reconfigure WIDTH=32, NREGS=16: write 32'hDEAD_BEEF to R15, read it back.
//    Clear takes 16 cycles.

Source files
------------

// File: rtl/reg_file_sb_if.sv
// Datapath-side bundle for reg_file_sb: write, issue, clear and two read ports.
// The master drives indices, data and strobes; the register file is the slave.
interface reg_file_sb_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
);
    localparam int AW = $clog2(NREGS);

    logic             LD_REG;
    logic [AW-1:0]    DR_In;
    logic [WIDTH-1:0] Bus_In;
    logic             Issue;
    logic [AW-1:0]    Issue_DR;
    logic             Clear_Req;
    logic [AW-1:0]    SR1_In;
    logic [AW-1:0]    SR2_In;
    logic [WIDTH-1:0] SR1OUT;
    logic [WIDTH-1:0] SR2OUT;
    logic             SR1_Pend;
    logic             SR2_Pend;
    logic             Clear_Busy;

    modport master (
        output LD_REG, DR_In, Bus_In, Issue, Issue_DR, Clear_Req, SR1_In, SR2_In,
        input  SR1OUT, SR2OUT, SR1_Pend, SR2_Pend, Clear_Busy
    );

    modport slave (
        input  LD_REG, DR_In, Bus_In, Issue, Issue_DR, Clear_Req, SR1_In, SR2_In,
        output SR1OUT, SR2OUT, SR1_Pend, SR2_Pend, Clear_Busy
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with write-to-read forwarding, per-register pending scoreboard
// and a one-register-per-cycle bulk clear sequencer.
module reg_file_sb #(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 8,
    parameter int BYPASS = 1
) (
    input  logic         Clk,
    input  logic         Reset,
    reg_file_sb_if.slave bus
);
    localparam int            AW    = $clog2(NREGS);
    localparam int            NRD   = 2;
    localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state, state_nxt;
    logic             idle;
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] pend, pend_nxt;

    logic [AW-1:0]    rd_idx  [NRD];
    logic [WIDTH-1:0] rd_data [NRD];
    logic [NRD-1:0]   rd_pend;

    // state register
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // end of sweep is detected on the last index, not on idx overflow
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.Clear_Req) state_nxt = CLEAR;
            CLEAR:   if (idx == LAST)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        idle           = (state == IDLE);
        bus.Clear_Busy = (state == CLEAR);
    end

    // issue after writeback: a new producer wins over the retiring one
    always_comb begin
        pend_nxt = pend;
        if (idle) begin
            if (bus.LD_REG)    pend_nxt[bus.DR_In]    = 1'b0;
            if (bus.Issue)     pend_nxt[bus.Issue_DR] = 1'b1;
            if (bus.Clear_Req) pend_nxt               = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            pend <= '0;
            idx  <= '0;
        end else begin
            pend <= pend_nxt;
            if (idle) begin
                if (bus.LD_REG)    regs[bus.DR_In] <= bus.Bus_In;
                if (bus.Clear_Req) idx <= '0;
            end else begin
                regs[idx] <= '0;
                idx       <= idx + AW'(1);
            end
        end
    end

    assign rd_idx[0] = bus.SR1_In;
    assign rd_idx[1] = bus.SR2_In;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic fwd;
        assign fwd        = (BYPASS != 0) && idle && bus.LD_REG && (bus.DR_In == rd_idx[p]);
        assign rd_data[p] = fwd ? bus.Bus_In : regs[rd_idx[p]];
        assign rd_pend[p] = idle && pend[rd_idx[p]] && !fwd;
    end

    assign bus.SR1OUT   = rd_data[0];
    assign bus.SR2OUT   = rd_data[1];
    assign bus.SR1_Pend = rd_pend[0];
    assign bus.SR2_Pend = rd_pend[1];
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: bypass and non-bypass 8x16 files plus a 16x32 file.
module tb_reg_file_sb;
    logic Clk = 1'b0;
    logic rst_a, rst_b, rst_c;

    always #5 Clk = ~Clk;

    reg_file_sb_if #(.WIDTH(16), .NREGS(8))  ia ();
    reg_file_sb_if #(.WIDTH(16), .NREGS(8))  ib ();
    reg_file_sb_if #(.WIDTH(32), .NREGS(16)) ic ();

    reg_file_sb #(.WIDTH(16), .NREGS(8),  .BYPASS(1)) dut_a (.Clk(Clk), .Reset(rst_a), .bus(ia.slave));
    reg_file_sb #(.WIDTH(16), .NREGS(8),  .BYPASS(0)) dut_b (.Clk(Clk), .Reset(rst_b), .bus(ib.slave));
    reg_file_sb #(.WIDTH(32), .NREGS(16), .BYPASS(1)) dut_c (.Clk(Clk), .Reset(rst_c), .bus(ic.slave));

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push(input string tag, input logic [31:0] v);
        sb.push_back('{tag: tag, val: v});
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL sb_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_a();
        ia.LD_REG = 0; ia.DR_In = '0; ia.Bus_In = '0; ia.Issue = 0;
        ia.Issue_DR = '0; ia.Clear_Req = 0;
    endtask

    task automatic idle_b();
        ib.LD_REG = 0; ib.DR_In = '0; ib.Bus_In = '0; ib.Issue = 0;
        ib.Issue_DR = '0; ib.Clear_Req = 0;
    endtask

    task automatic idle_c();
        ic.LD_REG = 0; ic.DR_In = '0; ic.Bus_In = '0; ic.Issue = 0;
        ic.Issue_DR = '0; ic.Clear_Req = 0;
    endtask

    initial begin
        int cnt;
        idle_a(); idle_b(); idle_c();
        ia.SR1_In = '0; ia.SR2_In = '0; ib.SR1_In = '0; ib.SR2_In = '0;
        ic.SR1_In = '0; ic.SR2_In = '0;
        rst_a = 1; rst_b = 1; rst_c = 1;
        tick(); tick();
        rst_a = 0; rst_b = 0; rst_c = 0;
        #1;
        push("rst_a_sr1", 0); chk(32'(ia.SR1OUT));
        push("rst_a_pend", 0); chk(32'(ia.SR1_Pend));
        push("rst_a_busy", 0); chk(32'(ia.Clear_Busy));
        push("rst_c_sr2", 0); chk(ic.SR2OUT);

        // write then read back next cycle
        tick();
        ia.LD_REG = 1; ia.DR_In = 3'd3; ia.Bus_In = 16'h1234;
        ib.LD_REG = 1; ib.DR_In = 3'd5; ib.Bus_In = 16'h1111;
        tick();
        idle_a(); idle_b();
        ia.SR1_In = 3'd3;
        #1;
        push("wr_rd_r3", 32'h1234); chk(32'(ia.SR1OUT));
        push("wr_rd_pend", 0);      chk(32'(ia.SR1_Pend));

        // same-cycle forwarding vs stored value
        tick();
        ia.LD_REG = 1; ia.DR_In = 3'd5; ia.Bus_In = 16'hBEEF; ia.SR2_In = 3'd5;
        ib.LD_REG = 1; ib.DR_In = 3'd5; ib.Bus_In = 16'hBEEF; ib.SR2_In = 3'd5;
        #1;
        push("byp1_same", 32'hBEEF); chk(32'(ia.SR2OUT));
        push("byp0_same", 32'h1111); chk(32'(ib.SR2OUT));
        tick();
        idle_a(); idle_b();
        #1;
        push("byp1_next", 32'hBEEF); chk(32'(ia.SR2OUT));
        push("byp0_next", 32'hBEEF); chk(32'(ib.SR2OUT));

        // scoreboard set / clear / set-wins
        tick();
        ia.Issue = 1; ia.Issue_DR = 3'd2;
        ib.Issue = 1; ib.Issue_DR = 3'd2;
        tick();
        idle_a(); idle_b();
        ia.SR1_In = 3'd2; ib.SR1_In = 3'd2;
        #1;
        push("pend_set", 1); chk(32'(ia.SR1_Pend));
        ia.LD_REG = 1; ia.DR_In = 3'd2; ia.Bus_In = 16'h0007;
        ib.LD_REG = 1; ib.DR_In = 3'd2; ib.Bus_In = 16'h0007;
        #1;
        push("pend_wr_byp1", 0);  chk(32'(ia.SR1_Pend));
        push("data_wr_byp1", 7);  chk(32'(ia.SR1OUT));
        push("pend_wr_byp0", 1);  chk(32'(ib.SR1_Pend));
        push("data_wr_byp0", 0);  chk(32'(ib.SR1OUT));
        tick();
        idle_a(); idle_b();
        #1;
        push("pend_after_a", 0); chk(32'(ia.SR1_Pend));
        push("pend_after_b", 0); chk(32'(ib.SR1_Pend));
        push("data_after_b", 7); chk(32'(ib.SR1OUT));
        ia.Issue = 1; ia.Issue_DR = 3'd2;
        ia.LD_REG = 1; ia.DR_In = 3'd2; ia.Bus_In = 16'h0009;
        tick();
        idle_a();
        #1;
        push("pend_set_wins", 1); chk(32'(ia.SR1_Pend));
        push("data_set_wins", 9); chk(32'(ia.SR1OUT));

        // fill, then bulk clear with ignored writes/issues mid-sequence
        for (int k = 0; k < 8; k++) begin
            tick();
            ia.LD_REG = 1; ia.DR_In = 3'(k); ia.Bus_In = 16'hFFFF;
        end
        tick();
        idle_a();
        ia.Clear_Req = 1;
        #1;
        push("clr_req_busy", 0); chk(32'(ia.Clear_Busy));
        for (int k = 0; k < 8; k++) begin
            tick();
            idle_a();
            ia.LD_REG = (k == 2); ia.DR_In = 3'(k); ia.Bus_In = 16'h1234;
            ia.Issue = (k == 2); ia.Issue_DR = 3'(k);
            ia.SR1_In = 3'(k);
            ia.SR2_In = (k == 0) ? 3'd7 : 3'(k - 1);
            #1;
            push($sformatf("clr_busy_%0d", k), 1); chk(32'(ia.Clear_Busy));
            push($sformatf("clr_old_%0d", k), 32'hFFFF); chk(32'(ia.SR1OUT));
            push($sformatf("clr_prev_%0d", k), (k == 0) ? 32'hFFFF : 32'h0);
            chk(32'(ia.SR2OUT));
            push($sformatf("clr_pend_%0d", k), 0); chk(32'(ia.SR1_Pend));
        end
        tick();
        idle_a();
        #1;
        push("clr_done_busy", 0); chk(32'(ia.Clear_Busy));
        for (int r = 0; r < 8; r++) begin
            ia.SR1_In = 3'(r);
            #1;
            push($sformatf("clr_zero_r%0d", r), 0); chk(32'(ia.SR1OUT));
            push($sformatf("clr_pend_r%0d", r), 0); chk(32'(ia.SR1_Pend));
        end

        // reset aborts a clear on its fourth cycle
        tick();
        ia.LD_REG = 1; ia.DR_In = 3'd1; ia.Bus_In = 16'hAAAA;
        tick();
        ia.DR_In = 3'd6; ia.Bus_In = 16'h6666;
        tick();
        idle_a();
        ia.Clear_Req = 1;
        tick();
        idle_a();
        tick();
        tick();
        tick();
        rst_a = 1;
        #1;
        push("abort_busy_c4", 1); chk(32'(ia.Clear_Busy));
        tick();
        rst_a = 0;
        ia.SR1_In = 3'd1; ia.SR2_In = 3'd6;
        #1;
        push("abort_busy", 0); chk(32'(ia.Clear_Busy));
        push("abort_r1", 0);   chk(32'(ia.SR1OUT));
        push("abort_r6", 0);   chk(32'(ia.SR2OUT));
        ia.LD_REG = 1; ia.DR_In = 3'd4; ia.Bus_In = 16'h4444; ia.SR1_In = 3'd4;
        #1;
        push("abort_wr_byp", 32'h4444); chk(32'(ia.SR1OUT));
        tick();
        idle_a();
        #1;
        push("abort_wr_rd", 32'h4444); chk(32'(ia.SR1OUT));

        // wide/deep configuration
        ic.LD_REG = 1; ic.DR_In = 4'd15; ic.Bus_In = 32'hDEAD_BEEF;
        tick();
        idle_c();
        ic.SR1_In = 4'd15;
        #1;
        push("c_r15", 32'hDEAD_BEEF); chk(ic.SR1OUT);
        ic.Clear_Req = 1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            ic.Clear_Req = 0;
            if (ic.Clear_Busy) cnt++;
            else if (cnt > 0) break;
        end
        push("c_busy_cycles", 16); chk(32'(cnt));
        push("c_r15_clr", 0);      chk(ic.SR1OUT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
